// File: rtl/aes_round_seq_if.sv
// Control/status bundle between the AES top-level controller (master)
// and the round sequencer (slave).
interface aes_round_seq_if #(
  parameter int P_RND_W = 4
);
  logic               iStAes;
  logic [1:0]         iKeyLen;
  logic               iDec;
  logic               iRoundEn;
  logic               iAbort;
  logic               oInitRoundFlag;
  logic               oFstRoundFlag;
  logic               oMidRoundFlag;
  logic               oLstRoundFlag;
  logic [P_RND_W-1:0] oRound;
  logic [P_RND_W-1:0] oKeyIdx;
  logic               oDecMode;
  logic               oBusy;
  logic               oAesDone;
  logic               oErr;

  modport master (
    output iStAes, iKeyLen, iDec, iRoundEn, iAbort,
    input  oInitRoundFlag, oFstRoundFlag, oMidRoundFlag, oLstRoundFlag,
           oRound, oKeyIdx, oDecMode, oBusy, oAesDone, oErr
  );

  modport slave (
    input  iStAes, iKeyLen, iDec, iRoundEn, iAbort,
    output oInitRoundFlag, oFstRoundFlag, oMidRoundFlag, oLstRoundFlag,
           oRound, oKeyIdx, oDecMode, oBusy, oAesDone, oErr
  );
endinterface

// File: rtl/aes_round_seq.sv
// AES round sequencer for 10/12/14-round operation with stall and abort.
// Define AES_ROUND_SEQ_DEC_EN to enable decrypt (down-counting key index).
module aes_round_seq #(
  parameter int P_RND_W = 4,
  parameter int P_NR128 = 10,
  parameter int P_NR192 = 12,
  parameter int P_NR256 = 14
) (
  input  logic           iClk,
  input  logic           iRsn,
  aes_round_seq_if.slave bus
);
  typedef enum logic [2:0] {
    S_IDLE, S_INIT, S_FIRST, S_MID, S_LAST, S_DONE
  } state_e;

  state_e             state_q, state_d;
  logic [P_RND_W-1:0] round_q, round_d;
  logic [P_RND_W-1:0] nr_q, nr_d;
  logic               dec_q, dec_d;
  logic               err_q, err_d;
  logic [P_RND_W-1:0] nr_sel;
  logic               dec_in;
  logic               en;

  assign en = bus.iRoundEn;

  always_comb begin
    nr_sel = '0;
    case (bus.iKeyLen)
      2'b00:   nr_sel = P_RND_W'(P_NR128);
      2'b01:   nr_sel = P_RND_W'(P_NR192);
      2'b10:   nr_sel = P_RND_W'(P_NR256);
      default: nr_sel = '0;
    endcase
  end

`ifdef AES_ROUND_SEQ_DEC_EN
  assign dec_in = bus.iDec;
`else
  logic unused_dec;
  assign unused_dec = bus.iDec;
  assign dec_in     = 1'b0;
`endif

  always_ff @(posedge iClk) begin
    if (!iRsn) begin
      state_q <= S_IDLE;
      round_q <= '0;
      nr_q    <= '0;
      dec_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      round_q <= round_d;
      nr_q    <= nr_d;
      dec_q   <= dec_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    round_d = round_q;
    nr_d    = nr_q;
    dec_d   = dec_q;
    err_d   = 1'b0;
    // Abort outranks every other transition, including DONE->IDLE.
    if (state_q != S_IDLE && bus.iAbort) begin
      state_d = S_IDLE;
      round_d = '0;
    end else begin
      case (state_q)
        S_IDLE: if (bus.iStAes && !bus.iAbort) begin
          if (bus.iKeyLen == 2'b11) begin
            err_d = 1'b1;
          end else begin
            state_d = S_INIT;
            round_d = '0;
            nr_d    = nr_sel;
            dec_d   = dec_in;
          end
        end
        S_INIT: if (en) begin
          state_d = S_FIRST;
          round_d = P_RND_W'(1);
        end
        S_FIRST: if (en) begin
          state_d = S_MID;
          round_d = round_q + P_RND_W'(1);
        end
        S_MID: if (en) begin
          if (round_q == nr_q - P_RND_W'(1)) state_d = S_LAST;
          round_d = round_q + P_RND_W'(1);
        end
        S_LAST: if (en) state_d = S_DONE;
        S_DONE: begin
          state_d = S_IDLE;
          round_d = '0;
        end
        default: begin
          state_d = S_IDLE;
          round_d = '0;
        end
      endcase
    end
  end

  assign bus.oInitRoundFlag = (state_q == S_INIT);
  assign bus.oFstRoundFlag  = (state_q == S_FIRST);
  assign bus.oMidRoundFlag  = (state_q == S_MID);
  assign bus.oLstRoundFlag  = (state_q == S_LAST);
  assign bus.oRound         = round_q;
  assign bus.oDecMode       = dec_q;
  assign bus.oBusy          = (state_q != S_IDLE);
  assign bus.oAesDone       = (state_q == S_DONE);
  assign bus.oErr           = err_q;

`ifdef AES_ROUND_SEQ_DEC_EN
  // dec_q outlives the operation, so gate on busy to keep the idle index at 0.
  assign bus.oKeyIdx = (dec_q && state_q != S_IDLE) ? (nr_q - round_q) : round_q;
`else
  assign bus.oKeyIdx = round_q;
`endif
endmodule

// File: tb/tb_aes_round_seq.sv
// Directed bench for aes_round_seq: round sequence, stall, abort, reset,
// illegal key length and start-during-DONE handling.
module tb_aes_round_seq;
  localparam int W = 4;
`ifdef AES_ROUND_SEQ_DEC_EN
  localparam bit DEC_EN = 1'b1;
`else
  localparam bit DEC_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rsn = 1'b0;
  int   errors = 0;
  int   checks = 0;

  aes_round_seq_if #(.P_RND_W(W)) bus ();

  aes_round_seq #(
    .P_RND_W(W), .P_NR128(10), .P_NR192(12), .P_NR256(14)
  ) dut (
    .iClk(clk),
    .iRsn(rsn),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] flags();
    return {bus.oInitRoundFlag, bus.oFstRoundFlag, bus.oMidRoundFlag, bus.oLstRoundFlag};
  endfunction

  // p: 0=INIT, 1=FIRST, 2..nr-1=MID, nr=LAST, nr+1=DONE
  task automatic chk_state(input int p, input int nr, input bit edec);
    int         r;
    logic [3:0] ef;
    r  = (p > nr) ? nr : p;
    ef = (p == 0) ? 4'b1000 : (p == 1) ? 4'b0100 : (p < nr) ? 4'b0010 :
         (p == nr) ? 4'b0001 : 4'b0000;
    chk($sformatf("flags p%0d", p), 32'(flags()), 32'(ef));
    chk($sformatf("round p%0d", p), 32'(bus.oRound), 32'(r));
    chk($sformatf("kidx p%0d", p), 32'(bus.oKeyIdx), 32'(edec ? nr - r : r));
    chk($sformatf("ctl p%0d", p), 32'({bus.oBusy, bus.oAesDone, bus.oErr, bus.oDecMode}),
        32'({1'b1, p == nr + 1, 1'b0, edec}));
  endtask

  task automatic chk_idle(input bit check_dec, input bit exp_dec);
    chk("idle_flags", 32'(flags()), 32'd0);
    chk("idle_round", 32'(bus.oRound), 32'd0);
    chk("idle_kidx", 32'(bus.oKeyIdx), 32'd0);
    chk("idle_ctl", 32'({bus.oBusy, bus.oAesDone, bus.oErr}), 32'd0);
    if (check_dec) chk("idle_dec", 32'(bus.oDecMode), 32'(exp_dec));
  endtask

  task automatic run_op(input logic [1:0] kl, input bit dec, input int stall_at,
                        input int stall_n, input int abort_at, input int rst_at,
                        input bit hold_next);
    int nr;
    bit edec;
    int p;
    int st;
    nr   = (kl == 2'b00) ? 10 : (kl == 2'b01) ? 12 : 14;
    edec = DEC_EN && dec;
    p    = 0;
    st   = stall_n;
    bus.iKeyLen  = kl;
    bus.iDec     = dec;
    bus.iStAes   = 1'b1;
    bus.iRoundEn = 1'b1;
    tick;
    // Latched operands must ignore later changes on these inputs.
    bus.iStAes  = 1'b0;
    bus.iKeyLen = 2'b11;
    bus.iDec    = ~dec;
    for (int g = 0; g < 64; g++) begin
      chk_state(p, nr, edec);
      if (p == abort_at) begin
        bus.iAbort = 1'b1;
        tick;
        bus.iAbort = 1'b0;
        chk_idle(1'b0, 1'b0);
        return;
      end
      if (p == rst_at) begin
        rsn = 1'b0;
        tick;
        rsn = 1'b1;
        chk_idle(1'b1, 1'b0);
        return;
      end
      if (p == nr + 1) begin
        if (hold_next) begin
          bus.iStAes  = 1'b1;
          bus.iKeyLen = 2'b01;
          bus.iDec    = 1'b0;
        end
        tick;
        chk_idle(1'b1, edec);
        return;
      end
      if (p == stall_at && st > 0) begin
        bus.iRoundEn = 1'b0;
        st--;
      end else begin
        bus.iRoundEn = 1'b1;
      end
      tick;
      if (bus.iRoundEn) p++;
    end
    chk("op_bound", 32'(p), 32'(nr + 1));
  endtask

  initial begin
    bus.iStAes   = 1'b0;
    bus.iKeyLen  = 2'b00;
    bus.iDec     = 1'b0;
    bus.iRoundEn = 1'b1;
    bus.iAbort   = 1'b0;
    rsn = 1'b0;
    tick;
    tick;
    chk_idle(1'b1, 1'b0);
    rsn = 1'b1;
    tick;

    run_op(2'b00, 1'b0, -1, 0, -1, -1, 1'b0);   // AES-128 encrypt
    run_op(2'b10, 1'b1, -1, 0, -1, -1, 1'b0);   // AES-256 decrypt
    run_op(2'b01, 1'b0,  5, 3, -1, -1, 1'b0);   // AES-192, 3-cycle stall at round 5

    // Illegal key length: one-cycle error, never busy.
    bus.iKeyLen = 2'b11;
    bus.iStAes  = 1'b1;
    tick;
    bus.iStAes = 1'b0;
    chk("err_pulse", 32'({bus.oErr, bus.oBusy, flags()}), 32'({1'b1, 1'b0, 4'b0000}));
    tick;
    chk("err_clear", 32'({bus.oErr, bus.oBusy, flags()}), 32'd0);
    run_op(2'b01, 1'b1, -1, 0, -1, -1, 1'b0);

    // Abort in IDLE blocks a coincident start.
    bus.iAbort  = 1'b1;
    bus.iStAes  = 1'b1;
    bus.iKeyLen = 2'b00;
    tick;
    bus.iAbort = 1'b0;
    bus.iStAes = 1'b0;
    chk("idle_abort", 32'({bus.oBusy, flags()}), 32'd0);

    run_op(2'b00, 1'b0, -1, 0,  4, -1, 1'b0);   // abort at round 4
    run_op(2'b00, 1'b1, -1, 0, 11, -1, 1'b0);   // abort coincident with DONE
    run_op(2'b10, 1'b0, -1, 0, -1,  7, 1'b0);   // reset at round 7
    run_op(2'b00, 1'b0, -1, 0, -1, -1, 1'b1);   // start held through DONE
    run_op(2'b01, 1'b0, -1, 0, -1, -1, 1'b0);   // ...accepted at the IDLE edge

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
